// File: rtl/branch_resolve_unit_pkg.sv
// Shared RISC-V branch definitions: datapath width, comparison codes, BHT counter encoding.
// Latency: n/a (types, constants and helper function only).
// Backpressure: n/a.
package branch_resolve_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_mode_e;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_cnt_e;

    // Saturating 2-bit predictor update.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != BHT_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != BHT_SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluation for EQ/NE/LT/GE/LTU/GEU; flags undefined codes.
// Latency: purely combinational.
// Backpressure: none.
module branch_compare #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_0,
    input  logic [W-1:0] in_1,
    input  logic [2:0]   mode,
    output logic         cond,
    output logic         legal
);
    import branch_resolve_unit_pkg::*;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (mode)
            BR_EQ:   cond = (in_0 == in_1);
            BR_NE:   cond = (in_0 != in_1);
            BR_LT:   cond = ($signed(in_0) <  $signed(in_1));
            BR_GE:   cond = ($signed(in_0) >= $signed(in_1));
            BR_LTU:  cond = (in_0 <  in_1);
            BR_GEU:  cond = (in_0 >= in_1);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, trains a 2-bit BHT, counts branches and mispredicts.
// Latency: result registered 1 cycle after accept; pred_taken is combinational.
// Backpressure: in_ready = !out_valid || out_ready; result held stable until consumed.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_0,
    input  logic [XLEN-1:0]  in_1,
    input  logic [2:0]       mode,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             mispredict,
    output logic             illegal,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    import branch_resolve_unit_pkg::*;

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             accept;
    logic             cond;
    logic             legal;
    logic             res_taken;
    logic             res_mp;
    logic [XLEN-1:0]  res_redirect;
    logic             unused_pred_pc;

    branch_compare #(.W(XLEN)) u_cmp (
        .in_0  (in_0),
        .in_1  (in_1),
        .mode  (mode),
        .cond  (cond),
        .legal (legal)
    );

    assign wr_idx         = pc[IDX_W+1:2];
    assign rd_idx         = pred_pc[IDX_W+1:2];
    assign unused_pred_pc = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    // Array read sees the pre-edge value, so a same-cycle update is not forwarded.
    assign pred_taken = bht[rd_idx][1];

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign res_taken    = legal && cond;
    assign res_mp       = (res_taken != pred_in);
    assign res_redirect = res_taken ? (pc + imm) : (pc + XLEN'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
            redirect_pc <= '0;
            br_count    <= '0;
            mp_count    <= '0;
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= BHT_WNT;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                taken       <= res_taken;
                mispredict  <= res_mp;
                illegal     <= !legal;
                redirect_pc <= res_redirect;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && legal) begin
                bht[wr_idx] <= bht_next(bht[wr_idx], res_taken);
                br_count    <= br_count + CNT_W'(1);
                if (res_mp)
                    mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule
